branch_resolver: RTL and testbench
==================================

# branch_resolver

Branch resolution and recovery unit pairing with the tournament branch predictor. It records each fetch-stage prediction (pc, direction, target) in a small in-order queue and retires the oldest entry when the memory stage resolves a branch. Each resolution produces the registered update packet the predictor trains on, plus redirect and flush signals on a mispredict. It sits between the fetch PC logic, the memory-stage branch outcome, and the predictor's update port.

## Interface
Parameters:
- DEPTH, 4 — in-flight prediction entries; power of two, ≥2
- FALLTHRU, 8 — byte offset of not-taken successor (branch + delay slot)

Ports:
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- pred_valid  in  1  fetch-stage branch prediction offered
- pred_pc  in  32  pc of predicted branch
- pred_taken  in  1  predicted direction
- pred_target  in  32  predicted taken target
- pred_ready  out  1  queue can accept (count < DEPTH)
- res_valid  in  1  memory-stage branch resolved this cycle
- res_taken  in  1  actual direction
- res_target  in  32  actual taken target
- upd_valid  out  1  predictor update strobe
- upd_pc  out  32  pc of resolved branch
- upd_taken  out  1  actual direction
- upd_pred  out  1  direction that was predicted
- upd_mis  out  1  resolution was a mispredict
- redirect_valid  out  1  fetch must restart at redirect_pc
- redirect_pc  out  32  correct next pc
- flushE  out  1  clear D→E register (equals redirect_valid)
- err_underflow  out  1  sticky: res_valid seen with empty queue

## Operation
- Enqueue when pred_valid && pred_ready && !mispredict-this-cycle; record {pc, taken, target} at tail.
- Resolution pops head when res_valid && !empty; resolutions strictly in program order.
- mispredict = head.taken != res_taken || (res_taken && head.target != res_target).
- correct pc = res_taken ? res_target : head.pc + FALLTHRU (32-bit wrap, no carry out).
- On mispredict: whole queue cleared (all younger entries wrong-path), including any same-cycle enqueue.
- Correct prediction: pop only; queue otherwise untouched; simultaneous enqueue and pop keeps count.
- res_valid with empty queue: no pop, no update, err_underflow set until rst.
- pred_valid while full: dropped, pred_ready stays low; fetch must hold.

## Timing
- pred_ready combinational from count; no full-bypass (full + pop does not raise ready same cycle).
- upd_*, redirect_*, flushE registered: asserted exactly one cycle after the res_valid edge, high one cycle.
- Back-to-back resolutions produce back-to-back upd_valid pulses.
- Reset: queue empty, count 0, pred_ready 1, all other outputs 0 (pcs 32'h0), counters 0.
- rst mid-operation discards all entries and any pending registered output.

## Configuration
- BR_STATS_EN defined: adds outputs cnt_branch (32) and cnt_mispred (32), incremented on every upd_valid / upd_valid&&upd_mis, wrap at 2^32, cleared by rst.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package bp_pkg: br_rec_t struct {pc, taken, target}, FALLTHRU default constant, pc width constant; shared with predictor.
- One sub-module br_fifo: parameterised DEPTH queue of br_rec_t with push, pop, clear, count, full, empty; clear has priority over push.

## Test plan
- Reset → pred_ready=1, upd_valid=0, redirect_valid=0, err_underflow=0.
- Enqueue {0x400, taken, 0x480}; resolve taken 0x480 → next cycle upd_valid=1, upd_mis=0, redirect_valid=0.
- Enqueue {0x400, not-taken}; resolve taken 0x500 → upd_mis=1, redirect_pc=0x500, flushE=1, queue empty.
- Enqueue {0x400, taken, 0x480}; resolve not-taken → redirect_pc=0x408; same-cycle enqueue of 0x410 discarded (count=0).
- Fill DEPTH=4 entries → pred_ready=0, fifth pred dropped; four correct resolutions → four consecutive upd_valid, pc order preserved.
- res_valid on empty queue → no upd_valid, err_underflow=1 until rst; with BR_STATS_EN, cnt_mispred counts only the mispredict case above.

Source files
------------

// File: rtl/bp_pkg.sv
// Types and constants shared between the branch predictor and the branch resolver.
package bp_pkg;

  localparam int unsigned PcWidth  = 32;
  localparam int unsigned FallThru = 8;

  typedef struct packed {
    logic [PcWidth-1:0] pc;
    logic               taken;
    logic [PcWidth-1:0] target;
  } br_rec_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch prediction, memory-stage resolution and predictor update signals of branch_resolver.
// With BR_STATS_EN defined, the branch and mispredict counters are carried as well.
interface branch_resolver_if;
  import bp_pkg::*;

  logic               pred_valid;
  logic [PcWidth-1:0] pred_pc;
  logic               pred_taken;
  logic [PcWidth-1:0] pred_target;
  logic               pred_ready;

  logic               res_valid;
  logic               res_taken;
  logic [PcWidth-1:0] res_target;

  logic               upd_valid;
  logic [PcWidth-1:0] upd_pc;
  logic               upd_taken;
  logic               upd_pred;
  logic               upd_mis;

  logic               redirect_valid;
  logic [PcWidth-1:0] redirect_pc;
  logic               flushE;
  logic               err_underflow;
`ifdef BR_STATS_EN
  logic [31:0]        cnt_branch;
  logic [31:0]        cnt_mispred;
`endif

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_taken, res_target,
    input  pred_ready, upd_valid, upd_pc, upd_taken, upd_pred, upd_mis,
    input  redirect_valid, redirect_pc, flushE, err_underflow
`ifdef BR_STATS_EN
    , input cnt_branch, cnt_mispred
`endif
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_taken, res_target,
    output pred_ready, upd_valid, upd_pc, upd_taken, upd_pred, upd_mis,
    output redirect_valid, redirect_pc, flushE, err_underflow
`ifdef BR_STATS_EN
    , output cnt_branch, cnt_mispred
`endif
  );

endinterface

// File: rtl/br_fifo.sv
// In-order queue of branch prediction records; clear wins over push and pop.
module br_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            clear_i,
  input  br_rec_t         wdata_i,
  output br_rec_t         rdata_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  br_rec_t         mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_en, pop_en;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push while full is dropped even if a pop happens in the same cycle.
  assign push_en = push_i && !full_o && !clear_i;
  assign pop_en  = pop_i && !empty_o && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolution and recovery: queues fetch predictions, retires them against memory-stage
// outcomes, and emits registered predictor updates and redirects. BR_STATS_EN adds counters.
module branch_resolver
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned FALLTHRU = FallThru
) (
  input  logic                clk,
  input  logic                rst,
  branch_resolver_if.slave    bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  br_rec_t         head;
  br_rec_t         wrec;
  logic [CntW-1:0] count;
  logic            full, empty;
  logic            pop, mis, push;
  logic [PcWidth-1:0] correct_pc;

  logic               upd_valid_q, upd_valid_d;
  logic [PcWidth-1:0] upd_pc_q, upd_pc_d;
  logic               upd_taken_q, upd_taken_d;
  logic               upd_pred_q, upd_pred_d;
  logic               upd_mis_q, upd_mis_d;
  logic               redir_valid_q, redir_valid_d;
  logic [PcWidth-1:0] redir_pc_q, redir_pc_d;
  logic               err_q, err_d;

  assign pop = bus.res_valid && !empty;
  assign mis = pop && ((head.taken != bus.res_taken) ||
                       (bus.res_taken && (head.target != bus.res_target)));
  assign correct_pc = bus.res_taken ? bus.res_target : head.pc + PcWidth'(FALLTHRU);
  // A mispredict squashes the same-cycle enqueue along with every queued entry.
  assign push = bus.pred_valid && bus.pred_ready && !mis;
  assign wrec = '{pc: bus.pred_pc, taken: bus.pred_taken, target: bus.pred_target};

  br_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (mis),
    .wdata_i (wrec),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    upd_valid_d   = pop;
    upd_mis_d     = mis;
    redir_valid_d = mis;
    upd_pc_d      = upd_pc_q;
    upd_taken_d   = upd_taken_q;
    upd_pred_d    = upd_pred_q;
    redir_pc_d    = redir_pc_q;
    err_d         = err_q || (bus.res_valid && empty);
    if (pop) begin
      upd_pc_d    = head.pc;
      upd_taken_d = bus.res_taken;
      upd_pred_d  = head.taken;
    end
    if (mis) redir_pc_d = correct_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      upd_pred_q    <= 1'b0;
      upd_mis_q     <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      upd_taken_q   <= upd_taken_d;
      upd_pred_q    <= upd_pred_d;
      upd_mis_q     <= upd_mis_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      err_q         <= err_d;
    end
  end

  assign bus.pred_ready     = (count < CntW'(DEPTH));
  assign bus.upd_valid      = upd_valid_q;
  assign bus.upd_pc         = upd_pc_q;
  assign bus.upd_taken      = upd_taken_q;
  assign bus.upd_pred       = upd_pred_q;
  assign bus.upd_mis        = upd_mis_q;
  assign bus.redirect_valid = redir_valid_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.flushE         = redir_valid_q;
  assign bus.err_underflow  = err_q;

`ifdef BR_STATS_EN
  logic [31:0] cnt_branch_q, cnt_branch_d;
  logic [31:0] cnt_mispred_q, cnt_mispred_d;

  always_comb begin
    cnt_branch_d  = cnt_branch_q + {31'd0, upd_valid_q};
    cnt_mispred_d = cnt_mispred_q + {31'd0, upd_valid_q && upd_mis_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_branch_q  <= '0;
      cnt_mispred_q <= '0;
    end else begin
      cnt_branch_q  <= cnt_branch_d;
      cnt_mispred_q <= cnt_mispred_d;
    end
  end

  assign bus.cnt_branch  = cnt_branch_q;
  assign bus.cnt_mispred = cnt_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver; expected values are hand-computed.
module tb_branch_resolver;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  branch_resolver_if bus ();

  branch_resolver #(
    .DEPTH    (4),
    .FALLTHRU (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_pred(input logic v, input logic [31:0] pc, input logic t,
                            input logic [31:0] tgt);
    bus.pred_valid  = v;
    bus.pred_pc     = pc;
    bus.pred_taken  = t;
    bus.pred_target = tgt;
  endtask

  task automatic drive_res(input logic v, input logic t, input logic [31:0] tgt);
    bus.res_valid  = v;
    bus.res_taken  = t;
    bus.res_target = tgt;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive_pred(1'b0, 32'h0, 1'b0, 32'h0);
    drive_res(1'b0, 1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_pred_ready", 32'(bus.pred_ready), 32'd1);
    check("rst_upd_valid", 32'(bus.upd_valid), 32'd0);
    check("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("rst_err_underflow", 32'(bus.err_underflow), 32'd0);
    check("rst_upd_pc", bus.upd_pc, 32'h0);
    check("rst_redirect_pc", bus.redirect_pc, 32'h0);

    // Correct taken prediction
    drive_pred(1'b1, 32'h400, 1'b1, 32'h480);
    tick();
    drive_pred(1'b0, 32'h0, 1'b0, 32'h0);
    drive_res(1'b1, 1'b1, 32'h480);
    tick();
    drive_res(1'b0, 1'b0, 32'h0);
    check("ok_upd_valid", 32'(bus.upd_valid), 32'd1);
    check("ok_upd_pc", bus.upd_pc, 32'h400);
    check("ok_upd_mis", 32'(bus.upd_mis), 32'd0);
    check("ok_upd_taken", 32'(bus.upd_taken), 32'd1);
    check("ok_upd_pred", 32'(bus.upd_pred), 32'd1);
    check("ok_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    tick();
    check("ok_upd_valid_pulse", 32'(bus.upd_valid), 32'd0);

    // Predicted not-taken, actually taken
    drive_pred(1'b1, 32'h400, 1'b0, 32'h0);
    tick();
    drive_pred(1'b0, 32'h0, 1'b0, 32'h0);
    drive_res(1'b1, 1'b1, 32'h500);
    tick();
    drive_res(1'b0, 1'b0, 32'h0);
    check("mis1_upd_mis", 32'(bus.upd_mis), 32'd1);
    check("mis1_upd_pred", 32'(bus.upd_pred), 32'd0);
    check("mis1_upd_taken", 32'(bus.upd_taken), 32'd1);
    check("mis1_redirect_valid", 32'(bus.redirect_valid), 32'd1);
    check("mis1_redirect_pc", bus.redirect_pc, 32'h500);
    check("mis1_flushE", 32'(bus.flushE), 32'd1);
    check("mis1_count", 32'(dut.u_fifo.count_o), 32'd0);
    tick();
    check("mis1_redirect_pulse", 32'(bus.redirect_valid), 32'd0);
    check("mis1_flushE_pulse", 32'(bus.flushE), 32'd0);

    // Predicted taken, actually not-taken, with a same-cycle enqueue that must be squashed
    drive_pred(1'b1, 32'h400, 1'b1, 32'h480);
    tick();
    drive_pred(1'b1, 32'h410, 1'b1, 32'h490);
    drive_res(1'b1, 1'b0, 32'h0);
    tick();
    drive_pred(1'b0, 32'h0, 1'b0, 32'h0);
    drive_res(1'b0, 1'b0, 32'h0);
    check("mis2_upd_mis", 32'(bus.upd_mis), 32'd1);
    check("mis2_redirect_pc", bus.redirect_pc, 32'h408);
    check("mis2_count", 32'(dut.u_fifo.count_o), 32'd0);
    check("mis2_pred_ready", 32'(bus.pred_ready), 32'd1);

    // Fill the queue, then offer a fifth prediction that must be dropped
    for (int i = 1; i <= 4; i++) begin
      drive_pred(1'b1, 32'(i) * 32'h100, 1'b1, 32'(i) * 32'h100 + 32'h40);
      tick();
    end
    check("full_pred_ready", 32'(bus.pred_ready), 32'd0);
    drive_pred(1'b1, 32'h500, 1'b1, 32'h540);
    tick();
    drive_pred(1'b0, 32'h0, 1'b0, 32'h0);
    check("full_drop_count", 32'(dut.u_fifo.count_o), 32'd4);
    check("full_idle_upd_valid", 32'(bus.upd_valid), 32'd0);

    // Four back-to-back correct resolutions retire in program order
    for (int i = 1; i <= 4; i++) begin
      drive_res(1'b1, 1'b1, 32'(i) * 32'h100 + 32'h40);
      tick();
      check("drain_upd_valid", 32'(bus.upd_valid), 32'd1);
      check("drain_upd_pc", bus.upd_pc, 32'(i) * 32'h100);
      check("drain_upd_mis", 32'(bus.upd_mis), 32'd0);
    end
    drive_res(1'b0, 1'b0, 32'h0);
    tick();
    check("drain_done_upd_valid", 32'(bus.upd_valid), 32'd0);
    check("drain_done_count", 32'(dut.u_fifo.count_o), 32'd0);
    check("drain_no_underflow", 32'(bus.err_underflow), 32'd0);

    // Resolution against an empty queue
    drive_res(1'b1, 1'b1, 32'h700);
    tick();
    drive_res(1'b0, 1'b0, 32'h0);
    check("under_upd_valid", 32'(bus.upd_valid), 32'd0);
    check("under_err", 32'(bus.err_underflow), 32'd1);
    tick();
    tick();
    check("under_err_sticky", 32'(bus.err_underflow), 32'd1);
    check("under_no_redirect", 32'(bus.redirect_valid), 32'd0);

`ifdef BR_STATS_EN
    check("stats_branch", bus.cnt_branch, 32'd7);
    check("stats_mispred", bus.cnt_mispred, 32'd2);
`endif

    // Reset mid-operation discards queued entries and pending outputs
    drive_pred(1'b1, 32'h800, 1'b1, 32'h880);
    tick();
    drive_pred(1'b0, 32'h0, 1'b0, 32'h0);
    drive_res(1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_res(1'b0, 1'b0, 32'h0);
    check("rst2_err", 32'(bus.err_underflow), 32'd0);
    check("rst2_upd_valid", 32'(bus.upd_valid), 32'd0);
    check("rst2_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("rst2_count", 32'(dut.u_fifo.count_o), 32'd0);
`ifdef BR_STATS_EN
    check("rst2_stats_branch", bus.cnt_branch, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
